// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, fetch queue, redirect and HALT handling
// Ports: clk, rst_n (async active-low); pc_o/inst_i to the combinational instr_mem;
// dec_valid_o/dec_inst_o/dec_pc_o/dec_ready_i queue head to decode; redirect_i/redirect_pc_i
// taken-branch redirect from execute; halted_o high while fetch is stopped after a HALT.
module fetch_unit #(
    parameter int              FQ_DEPTH = 2,
    parameter logic [31:0]     RESET_PC = 32'd0,
    parameter int              WIDTH    = 32,
    parameter int              OPC_W    = 5,
    parameter logic [OPC_W-1:0] HALT_OPC = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      pc_o,
    input  logic [WIDTH-1:0] inst_i,
    output logic             dec_valid_o,
    output logic [WIDTH-1:0] dec_inst_o,
    output logic [31:0]      dec_pc_o,
    input  logic             dec_ready_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             halted_o
);
    localparam int AW = $clog2(FQ_DEPTH);
    localparam logic [AW:0] FULL_CNT = FQ_DEPTH[AW:0];
    typedef enum logic {RUN, HALTED} state_t;
    state_t state, state_nxt;
    logic [31:0] pc;
    logic [WIDTH-1:0] inst_q [FQ_DEPTH];
    logic [31:0] pc_q [FQ_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic pop, fire, full;
    assign full        = count == FULL_CNT;
    assign pop         = dec_valid_o & dec_ready_i;
    // a pop in the same cycle frees a slot, so a full queue still sustains one word per cycle
    assign fire        = (state == RUN) & (~full | pop) & ~redirect_i;
    assign pc_o        = pc;
    assign dec_valid_o = count != '0;
    assign dec_inst_o  = inst_q[rd_ptr];
    assign dec_pc_o    = pc_q[rd_ptr];
    assign halted_o    = state == HALTED;
    // opcode is only inspected when firing, so an X on inst_i outside a fetch cannot leak in
    always_comb
        state_nxt = redirect_i ? RUN :
                    (fire && inst_i[WIDTH-1 -: OPC_W] == HALT_OPC) ? HALTED : state;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            pc     <= redirect_pc_i;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fire) begin
                pc     <= pc + 32'd1;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, fire} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk)
        if (fire) begin
            inst_q[wr_ptr] <= inst_i;
            pc_q[wr_ptr]   <= pc;
        end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        ready = 0;
    logic        redirect = 0;
    logic [31:0] redirect_pc = 0;
    logic        halted;
    logic        xmode = 0;
    logic [31:0] prog [8];
    int          checks = 0;
    int          failures = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_o(pc), .inst_i(inst),
        .dec_valid_o(dec_valid), .dec_inst_o(dec_inst), .dec_pc_o(dec_pc),
        .dec_ready_i(ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .halted_o(halted)
    );

    always #5 clk = ~clk;

    assign inst = xmode ? 'x : (pc < 32'd8 ? prog[pc[2:0]] : 32'h0);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst_n = 0;
        redirect = 0;
        ready = rdy;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset;
        rst_n = 0;
        tick();
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dec_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    endtask

    task automatic test_program;
        do_reset(1'b1);
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL prog_first_valid got=%b exp=0", dec_valid); end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (dec_valid !== 1'b1 || dec_pc !== k) begin failures++; $display("FAIL prog_pc[%0d] valid=%b got=%0h exp=%0h", k, dec_valid, dec_pc, k); end
            checks++; if (dec_inst !== prog[k]) begin failures++; $display("FAIL prog_inst[%0d] got=%0h exp=%0h", k, dec_inst, prog[k]); end
        end
    endtask

    task automatic test_halt;
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
        xmode = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++; if (pc !== 32'd6 || halted !== 1'b1) begin failures++; $display("FAIL halt_hold[%0d] pc=%0h halted=%b exp pc=6 halted=1", k, pc, halted); end
        end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL halt_drained got=%b exp=0", dec_valid); end
        xmode = 0;
        redirect = 1; redirect_pc = 32'd2;
        tick();
        redirect = 0;
        checks++; if (halted !== 1'b0 || pc !== 32'd2) begin failures++; $display("FAIL halt_resume halted=%b pc=%0h exp 0/2", halted, pc); end
        tick();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'd2) begin failures++; $display("FAIL halt_refetch valid=%b pc=%0h exp 1/2", dec_valid, dec_pc); end
    endtask

    task automatic test_backpressure;
        do_reset(1'b0);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (pc !== 32'd2 || dec_pc !== 32'd0) begin failures++; $display("FAIL bp_hold[%0d] pc=%0h head=%0h exp 2/0", k, pc, dec_pc); end
            tick();
        end
        ready = 1;
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++; if (dec_valid !== 1'b1 || dec_pc !== k) begin failures++; $display("FAIL bp_drain[%0d] valid=%b got=%0h exp=%0h", k, dec_valid, dec_pc, k); end
        end
    endtask

    task automatic test_redirect;
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) tick();
        ready = 0;
        tick();
        checks++; if (dec_pc !== 32'd3 || pc !== 32'd5) begin failures++; $display("FAIL redir_setup head=%0h pc=%0h exp 3/5", dec_pc, pc); end
        redirect = 1; redirect_pc = 32'd2;
        tick();
        redirect = 0; ready = 1;
        checks++; if (dec_valid !== 1'b0 || pc !== 32'd2) begin failures++; $display("FAIL redir_flush valid=%b pc=%0h exp 0/2", dec_valid, pc); end
        tick();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'd2 || pc !== 32'd3) begin failures++; $display("FAIL redir_target valid=%b head=%0h pc=%0h exp 1/2/3", dec_valid, dec_pc, pc); end
    endtask

    task automatic test_redirect_full_pop;
        ready = 0;
        tick();
        ready = 1; redirect = 1; redirect_pc = 32'd10;
        tick();
        redirect = 0; ready = 0;
        checks++; if (dec_valid !== 1'b0 || pc !== 32'd10) begin failures++; $display("FAIL redir_pop_flush valid=%b pc=%0h exp 0/a", dec_valid, pc); end
        tick();
        checks++; if (pc !== 32'd11 || dec_pc !== 32'd10 || dec_valid !== 1'b1) begin failures++; $display("FAIL redir_pop_next pc=%0h head=%0h valid=%b exp b/a/1", pc, dec_pc, dec_valid); end
    endtask

    task automatic test_async_reset;
        tick();
        checks++; if (dec_pc !== 32'd10 || pc !== 32'd12) begin failures++; $display("FAIL areset_setup head=%0h pc=%0h exp a/c", dec_pc, pc); end
        #1 rst_n = 0;
        #1;
        checks++; if (dec_valid !== 1'b0 || pc !== 32'd0) begin failures++; $display("FAIL areset_immediate valid=%b pc=%0h exp 0/0", dec_valid, pc); end
        #1 rst_n = 1; ready = 1;
        tick();
        checks++; if (dec_pc !== 32'd0 || pc !== 32'd1 || dec_valid !== 1'b1) begin failures++; $display("FAIL areset_resume head=%0h pc=%0h valid=%b exp 0/1/1", dec_pc, pc, dec_valid); end
        tick();
        checks++; if (dec_pc !== 32'd1) begin failures++; $display("FAIL areset_next got=%0h exp=1", dec_pc); end
    endtask

    task automatic test_wrap;
        redirect = 1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 0;
        checks++; if (pc !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_target got=%0h exp=ffffffff", pc); end
        tick();
        checks++; if (pc !== 32'd0 || dec_pc !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_pc pc=%0h head=%0h exp 0/ffffffff", pc, dec_pc); end
        tick();
        checks++; if (dec_pc !== 32'd0 || dec_valid !== 1'b1) begin failures++; $display("FAIL wrap_head got=%0h valid=%b exp 0/1", dec_pc, dec_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        prog[0] = {5'd1, 27'd0};
        prog[1] = {5'd1, 27'd2};
        prog[2] = {5'd2, 27'd0};
        prog[3] = {5'd3, 27'd0};
        prog[4] = {5'd4, 27'h7FF_FFFE};
        prog[5] = {5'd31, 27'd0};
        prog[6] = 32'h0;
        prog[7] = 32'h0;
        test_reset();
        test_program();
        test_halt();
        test_backpressure();
        test_redirect();
        test_redirect_full_pop();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
